// File: rtl/master_input_control.sv
// Read-side control for the systolic array input path: streams one input
// sub-matrix out of the per-row banks with a one-cycle skew per bank.
module master_input_control #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               done,
    input  logic [ADDR_WIDTH-1:0]              rd_base_addr,
    input  logic [$clog2(SYS_ARR_COLS)-1:0]    num_vecs_read,
    input  logic [$clog2(SYS_ARR_ROWS)-1:0]    num_lanes_read,
    output logic [SYS_ARR_ROWS-1:0]            rd_en,
    output logic [SYS_ARR_ROWS*ADDR_WIDTH-1:0] rd_addr,
    output logic [SYS_ARR_ROWS-1:0]            lane_valid
);

    localparam int LW = $clog2(SYS_ARR_ROWS);
    localparam int VW = $clog2(SYS_ARR_COLS);
    localparam int CW = LW + VW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                         r_state;
    logic [CW-1:0]                  r_count;
    logic [ADDR_WIDTH-1:0]          r_base;
    logic [VW-1:0]                  r_vecs;
    logic [LW-1:0]                  r_lanes;
    logic                           r_done;
    logic [SYS_ARR_ROWS-1:0]        r_lane_valid;

    logic [CW-1:0]                  w_end;
    logic                           w_last;
    logic [SYS_ARR_ROWS-1:0]        w_rd_en;
    logic [SYS_ARR_ROWS*ADDR_WIDTH-1:0] w_rd_addr;

    // The run lasts L+R+1 cycles: last lane starts L cycles late and streams R+1 vectors
    assign w_end  = CW'(r_lanes) + CW'(r_vecs);
    assign w_last = (r_count == w_end);

    // Sequencer: latches the request on start and counts through the skewed sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_done       <= 1'b1;
            r_base       <= '0;
            r_vecs       <= '0;
            r_lanes      <= '0;
            r_lane_valid <= '0;
        end else begin
            r_lane_valid <= w_rd_en;
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (start) begin
                        r_base  <= rd_base_addr;
                        r_vecs  <= num_vecs_read;
                        r_lanes <= num_lanes_read;
                        r_state <= S_RUN;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_state <= S_RUN;
                        r_done  <= 1'b0;
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Lane k reads vector (count - k) while that vector index lies in 0..R
    always_comb begin
        w_rd_en   = '0;
        w_rd_addr = '0;
        for (int k = 0; k < SYS_ARR_ROWS; k++) begin
            if ((r_state == S_RUN) &&
                (CW'(k) <= CW'(r_lanes)) &&
                (r_count >= CW'(k)) &&
                (r_count <= CW'(k) + CW'(r_vecs))) begin
                w_rd_en[k] = 1'b1;
                w_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] =
                    r_base + ADDR_WIDTH'(r_count - CW'(k));
            end else begin
                w_rd_en[k] = 1'b0;
                w_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = '0;
            end
        end
    end

    assign done       = r_done;
    assign rd_en      = w_rd_en;
    assign rd_addr    = w_rd_addr;
    assign lane_valid = r_lane_valid;

endmodule

// File: tb/tb_master_input_control.sv
// Scoreboard bench for master_input_control: each scenario pushes per-cycle
// expectations when it issues start and pops them as the DUT sweeps.
module tb_master_input_control;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int AW   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 done;
    logic [AW-1:0]        rd_base_addr;
    logic [3:0]           num_vecs_read;
    logic [3:0]           num_lanes_read;
    logic [ROWS-1:0]      rd_en;
    logic [ROWS*AW-1:0]   rd_addr;
    logic [ROWS-1:0]      lane_valid;

    typedef struct packed {
        logic               done;
        logic [ROWS-1:0]    en;
        logic [ROWS-1:0]    lv;
        logic [ROWS*AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    master_input_control #(
        .SYS_ARR_ROWS(ROWS), .SYS_ARR_COLS(COLS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .rd_base_addr(rd_base_addr), .num_vecs_read(num_vecs_read),
        .num_lanes_read(num_lanes_read), .rd_en(rd_en), .rd_addr(rd_addr),
        .lane_valid(lane_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROWS-1:0] exp_en(int c, int r, int l);
        logic [ROWS-1:0] e = '0;
        for (int k = 0; k < ROWS; k++)
            if (k <= l && c >= k && c <= k + r) e[k] = 1'b1;
        return e;
    endfunction

    function automatic logic [ROWS*AW-1:0] exp_addr(int base, int c, int r, int l);
        logic [ROWS*AW-1:0] a = '0;
        int v;
        for (int k = 0; k < ROWS; k++) begin
            if (k <= l && c >= k && c <= k + r) begin
                v = base + c - k;
                a[k*AW +: AW] = v[AW-1:0];
            end
        end
        return a;
    endfunction

    // Issue start with the given request and queue the expected sweep
    task automatic launch(int base, int r, int l);
        exp_t e;
        int   n = l + r + 1;
        for (int c = 0; c < n; c++) begin
            e.done = 1'b0;
            e.en   = exp_en(c, r, l);
            e.lv   = (c == 0) ? '0 : exp_en(c - 1, r, l);
            e.addr = exp_addr(base, c, r, l);
            sb.push_back(e);
        end
        e.done = 1'b1;
        e.en   = '0;
        e.lv   = exp_en(n - 1, r, l);
        e.addr = '0;
        sb.push_back(e);
        rd_base_addr   = AW'(base);
        num_vecs_read  = 4'(r);
        num_lanes_read = 4'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        rd_base_addr = 8'h00; num_vecs_read = 4'd0; num_lanes_read = 4'd0;
        tick(); tick();
        total++;
        if ({done, rd_en, lane_valid, rd_addr} !== {1'b1, 16'h0, 16'h0, 128'h0}) begin
            bad++;
            $display("FAIL reset_state got done=%b en=%h lv=%h addr=%h exp done=1 en=0 lv=0 addr=0",
                     done, rd_en, lane_valid, rd_addr);
        end
        reset = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_full();
        exp_t e;
        int cyc = 0;
        launch(8'h10, 15, 15);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL full cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc == 30) begin
                total++;
                if (rd_en[15] !== 1'b1 || rd_addr[15*AW +: AW] !== 8'h1F) begin
                    bad++;
                    $display("FAIL full_lane15_last got en=%b addr=%h exp en=1 addr=1f",
                             rd_en[15], rd_addr[15*AW +: AW]);
                end
            end
            cyc++;
            tick();
        end
    endtask

    task automatic test_min();
        exp_t e;
        int cyc = 0;
        launch(8'h05, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL min cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc == 0) begin
                total++;
                if (rd_en !== 16'h0001 || rd_addr !== 128'h05) begin
                    bad++;
                    $display("FAIL min_single got en=%h addr=%h exp en=0001 addr=05", rd_en, rd_addr);
                end
            end else begin
                total++;
                if (lane_valid !== 16'h0001 || done !== 1'b1) begin
                    bad++;
                    $display("FAIL min_after got lv=%h done=%b exp lv=0001 done=1", lane_valid, done);
                end
            end
            cyc++;
            tick();
        end
    endtask

    task automatic test_partial();
        exp_t e;
        logic [2:0] tbl [6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
        int cyc = 0;
        launch(0, 3, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL partial cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc < 6) begin
                total++;
                if (rd_en[2:0] !== tbl[cyc] || rd_en[15:3] !== 13'h0) begin
                    bad++;
                    $display("FAIL partial_pattern cyc=%0d got en=%h exp en=%h", cyc, rd_en, {13'h0, tbl[cyc]});
                end
            end
            cyc++;
            tick();
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int cyc = 0;
        launch(250, 15, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL wrap cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc == 5 || cyc == 6) begin
                total++;
                if (rd_addr[AW-1:0] !== ((cyc == 5) ? 8'hFF : 8'h00)) begin
                    bad++;
                    $display("FAIL wrap_edge cyc=%0d got addr=%h exp addr=%h", cyc, rd_addr[AW-1:0],
                             (cyc == 5) ? 8'hFF : 8'h00);
                end
            end
            cyc++;
            tick();
        end
    endtask

    task automatic test_ignored_start();
        exp_t e;
        int cyc = 0;
        launch(8'h40, 7, 7);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL ignored_start cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc == 3) begin
                start = 1'b1; rd_base_addr = 8'hAA; num_vecs_read = 4'd2; num_lanes_read = 4'd1;
            end
            cyc++;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc = 0;
        launch(8'h20, 15, 15);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL reset_mid_pre cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            if (cyc == 5) begin
                sb.delete();
                reset = 1'b1;
            end
            cyc++;
            tick();
        end
        total++;
        if ({done, rd_en, lane_valid, rd_addr} !== {1'b1, 16'h0, 16'h0, 128'h0}) begin
            bad++;
            $display("FAIL reset_mid got done=%b en=%h lv=%h addr=%h exp done=1 en=0 lv=0 addr=0",
                     done, rd_en, lane_valid, rd_addr);
        end
        start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        total++;
        if (done !== 1'b1 || rd_en !== 16'h0) begin
            bad++;
            $display("FAIL reset_start_priority got done=%b en=%h exp done=1 en=0", done, rd_en);
        end
        cyc = 0;
        launch(8'h33, 2, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({done, rd_en, lane_valid, rd_addr} !== e) begin
                bad++;
                $display("FAIL fresh_start cyc=%0d got done=%b en=%h lv=%h addr=%h exp done=%b en=%h lv=%h addr=%h",
                         cyc, done, rd_en, lane_valid, rd_addr, e.done, e.en, e.lv, e.addr);
            end
            cyc++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_min();
        test_partial();
        test_wrap();
        test_ignored_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_input_control.md
Name: master_input_control

Overview:
- Read-side control for the systolic array input path: on a start pulse, streams one input sub-matrix out of the per-row input memory banks.
- Issues per-bank read enables and addresses with the diagonal skew the array needs: bank k lags bank k-1 by one cycle.
- Bank data must arrive at array row k aligned with the systolic wavefront.
- Sits between the master controller and the input memory banks.
- Mirror of the output-store control, which writes accumulator rows back to output memory.

Parameters:
- SYS_ARR_ROWS, 16, array rows = number of input memory banks/lanes (power of 2)
- SYS_ARR_COLS, 16, array columns; sets max vectors per sub-matrix (power of 2)
- ADDR_WIDTH, 8, address width of each input memory bank

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a read sequence
- done  output  1  high when idle (= ~busy)
- rd_base_addr  input  ADDR_WIDTH  address of vector 0 in every bank
- num_vecs_read  input  $clog2(SYS_ARR_COLS)  vectors to stream, 0-15 -> 1-16
- num_lanes_read  input  $clog2(SYS_ARR_ROWS)  active banks, 0-15 -> 1-16
- rd_en  output  SYS_ARR_ROWS  per-bank read enable, bit k -> bank k
- rd_addr  output  SYS_ARR_ROWS*ADDR_WIDTH  per-bank address, lane k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- lane_valid  output  SYS_ARR_ROWS  rd_en delayed one cycle; marks bank read data valid at array input

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values: state IDLE, count 0, done=1, rd_en=0, rd_addr=0, lane_valid=0.
- States:
  - IDLE: done=1. start=1 latches rd_base_addr, num_vecs_read (R) and num_lanes_read (L) into internal registers, clears count to 0, and moves to RUN next cycle.
  - RUN: done=0. count increments by 1 each cycle. When count == L+R, the next state is IDLE and count returns to 0.
- Counter width: $clog2(SYS_ARR_ROWS)+$clog2(SYS_ARR_COLS)+1 bits, enough to hold L+R up to 30 without overflow.
- RUN length: exactly L+R+1 cycles. done rises the cycle after the last RUN cycle.
- rd_en, combinational from registered state:
  - rd_en[k]=1 iff state==RUN, k<=L, and k <= count <= k+R.
  - Lanes above L are never enabled.
- rd_addr:
  - Lane k = latched_base + (count - k), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH), only while rd_en[k]=1.
  - Otherwise lane k drives 0.
- lane_valid: registered copy of rd_en, a one-cycle delay matching the synchronous-read memory latency. Cleared by reset.
- start while in RUN: ignored. No restart, no re-latch of inputs.
- start and reset in the same cycle: reset wins, block stays IDLE.
- Reset mid-RUN:
  - Next cycle is IDLE with rd_en=0 and done=1.
  - lane_valid=0 the same next cycle, because reset clears the register.
- Input changes during RUN: rd_base_addr, num_vecs_read and num_lanes_read have no effect, since latched copies are used.
- Back-to-back operation: start asserted in the first IDLE cycle after RUN is accepted, so there is one IDLE bubble between sequences.

Test Plan:
- Full sub-matrix: reset, then start with base=0x10, R=15, L=15.
  - done=0 for 31 cycles.
  - Lane 0 rd_en for counts 0-15 with addr 0x10..0x1F.
  - Lane 15 rd_en for counts 15-30 with addr 0x10..0x1F.
  - lane_valid equals rd_en delayed 1 cycle; done=1 at cycle 32.
- Minimum size: base=0x05, R=0, L=0.
  - Exactly one RUN cycle with rd_en=16'h0001 and lane 0 addr 0x05.
  - All other lanes have rd_en=0 and addr 0; lane_valid=16'h0001 the next cycle.
- Partial lanes/vectors: base=0, R=3, L=2.
  - 6 RUN cycles; rd_en per count: 001, 011, 111, 111, 110, 100 (bits 2..0).
  - Lane 2 addresses 0..3 at counts 2..5.
  - Bits 15:3 stay 0 throughout.
- Address wrap: ADDR_WIDTH=8, base=250, R=15, L=0.
  - Lane 0 addresses 250..255, then 0..9.
  - done returns high after 16 cycles.
- Ignored start and latched inputs:
  - Start R=7, L=7.
  - At count 3, pulse start again and change base, R and L.
  - The sequence still lasts 15 cycles using the original values.
- Reset mid-operation and priority:
  - Start R=15, L=15; assert reset at count 5. Next cycle done=1, rd_en=0, lane_valid=0.
  - Then start and reset together -> stays IDLE.
  - Then a fresh start runs normally.
